// File: rtl/venus_wb_pkg.sv
// ----------------------------------------------------------------------------
// venus_wb_pkg
// Shared definitions for the write-back arbiter slice: default widths, the
// write-back request record, and a small modulo-increment helper used by the
// round-robin pointer.
// ----------------------------------------------------------------------------
package venus_wb_pkg;

    localparam int NUM_REQ = 3;   // default number of write-back requesters
    localparam int DATA_W  = 32;  // register data width
    localparam int AW      = 5;   // register address width (2**AW registers)
    localparam int FLAG_W  = 6;   // flag register width

    // One pending write-back as seen by the arbiter.
    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              flag_we;
        logic [FLAG_W-1:0] flag;
    } wb_req_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_if
// Requester side of the write-back arbiter: per-requester valid/ready plus the
// packed address, data and flag fields (requester i occupies the LSB-first
// slice i).
//   master : execute units (drive valid/addr/data/flags, observe ready)
//   slave  : the arbiter (observes requests, drives ready)
// ----------------------------------------------------------------------------
interface writeback_arbiter_if #(
    parameter int NUM_REQ = venus_wb_pkg::NUM_REQ,
    parameter int DATA_W  = venus_wb_pkg::DATA_W,
    parameter int AW      = venus_wb_pkg::AW,
    parameter int FLAG_W  = venus_wb_pkg::FLAG_W
);

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*AW-1:0]     req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_flag_we_i;
    logic [NUM_REQ*FLAG_W-1:0] req_flag_i;

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_flag_we_i, req_flag_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_flag_we_i, req_flag_i,
        output req_ready_o
    );

endinterface

// File: rtl/writeback_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The winner is the first valid index at or after ptr,
// wrapping modulo N; ptr moves to winner+1 whenever a grant is issued and
// holds otherwise.
//   clk, rst : clock, asynchronous active-low reset (ptr -> 0)
//   valid    : N request lines
//   grant    : one-hot (or zero) grant, combinational from valid and ptr
// ----------------------------------------------------------------------------
module rr_arbiter
    import venus_wb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [N-1:0]  upper_mask;
    logic [N-1:0]  upper;
    logic [N-1:0]  pick_src;

    // Requests at or above ptr take priority; if there are none the search
    // has wrapped and the lowest valid index wins. Isolating the lowest set
    // bit of the chosen vector yields a one-hot grant.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        upper_mask = ~((N'(1) << ptr) - N'(1));
        upper      = valid & upper_mask;
        pick_src   = (|upper) ? upper : valid;
        grant      = pick_src & (~pick_src + N'(1));
        ptr_next   = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                ptr_next = PW'(wrap_inc(i, N));
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Shares the single register-file write-back port and the flag register write
// among NUM_REQ execute units (round-robin, valid/ready), and keeps the
// per-register reservation scoreboard exposed as busy_o.
//   clk, rst        : clock, asynchronous active-low reset
//   req_if (slave)  : requester valid/ready, addr, data, flag_we, flag
//   rsv_valid_i/rsv_addr_i/rsv_ready_o : issue-stage reservation handshake
//   busy_o          : reservation bitmap, 1 = write outstanding
//   wb_o/wb_addr_o/wb_data_o     : registered register-file write port
//   flag_write_o/flag_data_o     : registered flag register write port
// Optional build macro WB_ARB_ERR_EN adds err_o, a sticky flag raised when a
// write-back retires to a register that was not reserved.
// The parameters must match those of the connected interface instance.
// ----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int NUM_REQ = venus_wb_pkg::NUM_REQ,
    parameter int DATA_W  = venus_wb_pkg::DATA_W,
    parameter int AW      = venus_wb_pkg::AW,
    parameter int FLAG_W  = venus_wb_pkg::FLAG_W
) (
    input  logic                clk,
    input  logic                rst,
    writeback_arbiter_if.slave  req_if,
    input  logic                rsv_valid_i,
    input  logic [AW-1:0]       rsv_addr_i,
    output logic                rsv_ready_o,
    output logic [2**AW-1:0]    busy_o,
    output logic                wb_o,
    output logic [AW-1:0]       wb_addr_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic                flag_write_o,
    output logic [FLAG_W-1:0]   flag_data_o
`ifdef WB_ARB_ERR_EN
    ,
    output logic                err_o
`endif
);

    localparam int NREG = 2**AW;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic               any_grant;
    logic [AW-1:0]      sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_flag_we;
    logic [FLAG_W-1:0]  sel_flag;
    logic [NREG-1:0]    set_mask;
    logic [NREG-1:0]    clr_mask;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .valid (req_if.req_valid_i),
        .grant (grant)
    );

    // Handshakes are suppressed while reset is held so nothing is accepted
    // into a pipeline that reset is about to discard.
    assign ready              = grant & {NUM_REQ{rst}};
    assign req_if.req_ready_o = ready;
    assign any_grant          = |ready;

    // A busy register is refused (WAW stall); the issue stage retries.
    assign rsv_ready_o = rst & rsv_valid_i & ~busy_o[rsv_addr_i];

    // Steer the winning requester's fields to the output stage.
    always_comb begin
        sel_addr    = '0;
        sel_data    = '0;
        sel_flag_we = 1'b0;
        sel_flag    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                sel_addr    = req_if.req_addr_i[i*AW +: AW];
                sel_data    = req_if.req_data_i[i*DATA_W +: DATA_W];
                sel_flag_we = req_if.req_flag_we_i[i];
                sel_flag    = req_if.req_flag_i[i*FLAG_W +: FLAG_W];
            end
        end
    end

    // Output stage: strobes pulse for one cycle per accepted request; data
    // fields hold their last value while the strobes are low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_o         <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            flag_write_o <= 1'b0;
            flag_data_o  <= '0;
        end else begin
            wb_o         <= any_grant;
            flag_write_o <= any_grant & sel_flag_we;
            if (any_grant) begin
                wb_addr_o <= sel_addr;
                wb_data_o <= sel_data;
            end
            if (any_grant && sel_flag_we) begin
                flag_data_o <= sel_flag;
            end
        end
    end

    // The clear retires the write-back currently on the port (the register
    // cell writes at the end of this cycle); a same-edge set of the same
    // register wins because it is OR-ed in after the clear.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_ready_o) begin
            set_mask[rsv_addr_i] = 1'b1;
        end
        if (wb_o) begin
            clr_mask[wb_addr_o] = 1'b1;
        end
    end

    // NOTE: the scoreboard is a flop bitmap, not a RAM, and must be reset:
    // stale reservations after reset would stall issue forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_o <= '0;
        end else begin
            busy_o <= (busy_o & ~clr_mask) | set_mask;
        end
    end

`ifdef WB_ARB_ERR_EN
    // Sticky: a retiring write-back whose register was not reserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (wb_o && !busy_o[wb_addr_o]) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter
// Self-checking bench for writeback_arbiter. A behavioural model (round-robin
// pointer as an integer, scoreboard as a bit vector, one-stage write-back
// record) is compared against the DUT on every falling edge; directed phases
// pin the model with hand-computed expectations, then a randomized phase with
// legal requester behaviour runs against the model.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;
    import venus_wb_pkg::*;

    localparam int N    = NUM_REQ;
    localparam int NREG = 2**AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_REQ(N), .DATA_W(DATA_W), .AW(AW), .FLAG_W(FLAG_W)) req_if ();

    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_ready;
    logic [NREG-1:0]   busy;
    logic              wb;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flag_write;
    logic [FLAG_W-1:0] flag_data;
`ifdef WB_ARB_ERR_EN
    logic              err;
`endif

    writeback_arbiter #(.NUM_REQ(N), .DATA_W(DATA_W), .AW(AW), .FLAG_W(FLAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if),
        .rsv_valid_i  (rsv_valid),
        .rsv_addr_i   (rsv_addr),
        .rsv_ready_o  (rsv_ready),
        .busy_o       (busy),
        .wb_o         (wb),
        .wb_addr_o    (wb_addr),
        .wb_data_o    (wb_data),
        .flag_write_o (flag_write),
        .flag_data_o  (flag_data)
`ifdef WB_ARB_ERR_EN
        ,
        .err_o        (err)
`endif
    );

    // Stimulus state: one request record and valid bit per requester.
    wb_req_t req [N];
    bit      vld [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_if.req_valid_i[i]                  = vld[i];
            req_if.req_addr_i[i*AW +: AW]          = req[i].addr;
            req_if.req_data_i[i*DATA_W +: DATA_W]  = req[i].data;
            req_if.req_flag_we_i[i]                = req[i].flag_we;
            req_if.req_flag_i[i*FLAG_W +: FLAG_W]  = req[i].flag;
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            req[i] = '0;
        end
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int                m_ptr;
    bit [NREG-1:0]     m_busy;
    bit                m_wb;
    logic [AW-1:0]     m_addr;
    logic [DATA_W-1:0] m_data;
    bit                m_fw;
    logic [FLAG_W-1:0] m_fdata;
    bit                m_err;
    int                last_win = -1;  // grant consumed at the coming edge

    task automatic model_reset();
        m_ptr    = 0;
        m_busy   = '0;
        m_wb     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_fw     = 1'b0;
        m_fdata  = '0;
        m_err    = 1'b0;
        last_win = -1;
    endtask

    initial model_reset();

    always @(negedge clk) begin : compare
        int            win;
        int            idx;
        bit            acc;
        bit [NREG-1:0] nb;
        logic [N-1:0]  exp_ready;

        if (!rst) model_reset();

        check("wb_o", wb, m_wb);
        check("wb_addr_o", wb_addr, m_addr);
        check("wb_data_o", wb_data, m_data);
        check("flag_write_o", flag_write, m_fw);
        check("flag_data_o", flag_data, m_fdata);
        check("busy_o", busy, m_busy);
`ifdef WB_ARB_ERR_EN
        check("err_o", err, m_err);
`endif

        win = -1;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && vld[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        acc = rst && rsv_valid && !m_busy[rsv_addr];
        check("req_ready_o", req_if.req_ready_o, exp_ready);
        check("rsv_ready_o", rsv_ready, acc);

        if (rst) begin
            nb = m_busy;
            if (m_wb) begin
                if (!m_busy[m_addr]) m_err = 1'b1;
                nb[m_addr] = 1'b0;
            end
            if (acc) nb[rsv_addr] = 1'b1;
            m_busy = nb;
            m_wb   = (win >= 0);
            m_fw   = 1'b0;
            if (win >= 0) begin
                m_addr = req[win].addr;
                m_data = req[win].data;
                m_fw   = req[win].flag_we;
                if (req[win].flag_we) m_fdata = req[win].flag;
                m_ptr = (win + 1) % N;
            end
        end
        last_win = win;
    end

    // ------------------------------------------------------------------
    // Directed phases, then randomized traffic
    // ------------------------------------------------------------------
    logic [N-1:0]  rr_grant [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [AW-1:0] rr_addr  [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Reset state, with requests presented to show ready is gated.
        tick();
        for (int i = 0; i < N; i++) vld[i] = 1'b1;
        rsv_valid = 1'b1;
        drive();
        #1;
        check("rst_wb", wb, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_flag_data", flag_data, 0);
        check("rst_ready", req_if.req_ready_o, 0);
        check("rst_rsv_ready", rsv_ready, 0);
        clear_inputs();
        tick();
        rst = 1'b1;

        // Flags: requester 2 writes r3 with flags 6'b101010 (r3 unreserved).
        tick();
        req[2] = '{addr: 5'd3, data: 32'h0000_0033, flag_we: 1'b1, flag: 6'b101010};
        vld[2] = 1'b1;
        drive();
        #1 check("flag_grant", req_if.req_ready_o, 3'b100);
        tick();
        vld[2] = 1'b0;
        drive();
        check("flag_write_hi", flag_write, 1);
        check("flag_data", flag_data, 6'b101010);
        check("flag_wb_addr", wb_addr, 3);
`ifdef WB_ARB_ERR_EN
        check("err_before", err, 0);
`endif
        tick();
        check("flag_write_lo", flag_write, 0);
        check("flag_data_hold", flag_data, 6'b101010);
`ifdef WB_ARB_ERR_EN
        check("err_set", err, 1);
        tick();
        check("err_sticky", err, 1);
`endif

        // Round robin: all valid continuously with addresses 1,2,3.
        for (int i = 0; i < N; i++) begin
            req[i] = '{addr: AW'(i + 1), data: DATA_W'(32'h100 + i), flag_we: 1'b0, flag: '0};
            vld[i] = 1'b1;
        end
        drive();
        for (int c = 0; c < 6; c++) begin
            #1 check("rr_grant", req_if.req_ready_o, rr_grant[c]);
            tick();
            check("rr_wb_addr", wb_addr, rr_addr[c]);
            check("rr_flag_write", flag_write, 0);
        end

        // Mid-stream reset: one more grant moves ptr to 1, then reset.
        #1 check("pre_rst_grant", req_if.req_ready_o, 3'b001);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_wb", wb, 0);
        check("mid_rst_wb_addr", wb_addr, 0);
        check("mid_rst_wb_data", wb_data, 0);
        check("mid_rst_flag_data", flag_data, 0);
        check("mid_rst_ready", req_if.req_ready_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("post_rst_first_grant", req_if.req_ready_o, 3'b001);
        tick();
        clear_inputs();

        // Reservation cycle on r5, written by requester 1.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        #1 check("r5_rsv_ready", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        check("r5_busy_set", busy[5], 1);
        req[1] = '{addr: 5'd5, data: 32'hDEAD_BEEF, flag_we: 1'b0, flag: '0};
        vld[1] = 1'b1;
        drive();
        #1 check("r5_grant", req_if.req_ready_o, 3'b010);
        tick();
        vld[1] = 1'b0;
        drive();
        check("r5_wb", wb, 1);
        check("r5_wb_data", wb_data, 32'hDEAD_BEEF);
        check("r5_wb_addr", wb_addr, 5);
        check("r5_busy_still", busy[5], 1);
        tick();
        check("r5_wb_done", wb, 0);
        check("r5_busy_clr", busy[5], 0);

        // WAW stall on r7.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        #1 check("r7_first", rsv_ready, 1);
        tick();
        #1 check("r7_second", rsv_ready, 0);
        tick();
        req[0] = '{addr: 5'd7, data: 32'h0000_0077, flag_we: 1'b0, flag: '0};
        vld[0] = 1'b1;
        drive();
        #1 check("r7_stall_accept", rsv_ready, 0);
        tick();
        vld[0] = 1'b0;
        drive();
        #1 check("r7_stall_wb", rsv_ready, 0);
        tick();
        #1 check("r7_retry", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        check("r7_busy_again", busy[7], 1);

        // Same-edge set/clear on r9 (unreserved write-back retiring while
        // a new reservation of r9 is accepted).
        req[2] = '{addr: 5'd9, data: 32'h0000_0099, flag_we: 1'b0, flag: '0};
        vld[2] = 1'b1;
        drive();
        tick();
        vld[2] = 1'b0;
        drive();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        #1;
        check("r9_wb", wb, 1);
        check("r9_rsv_ready", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        check("r9_busy_set_wins", busy[9], 1);
        clear_inputs();

        // Randomized traffic with legal requester behaviour.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1500) rst = 1'b0;
            if (c == 1503) rst = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (last_win == i) vld[i] = 1'b0;
                if (!vld[i] && $urandom_range(0, 2) != 0) begin
                    vld[i]         = 1'b1;
                    req[i].addr    = AW'($urandom_range(0, 7));
                    req[i].data    = $urandom;
                    req[i].flag_we = 1'($urandom_range(0, 1));
                    req[i].flag    = FLAG_W'($urandom);
                end
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = AW'($urandom_range(0, 7));
            drive();
        end

        clear_inputs();
        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the single register-file write-back port and the 6-bit flag register write between several execution units (ALU, load unit, multiplier) using round-robin arbitration with a valid/ready handshake. It also keeps the per-register write-reservation scoreboard that the register cells' `w_reserve` lines expose. Issue reserves a destination register, and the winning write-back releases it. The block sits between the execute units and the register file / flag register.

## Interface
- `NUM_REQ`, default 3: number of write-back requesters (2..8).
- `DATA_W`, default 32: register data width.
- `AW`, default 5: register address width (2^AW registers).
- `FLAG_W`, default 6: flag register width.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `req_valid_i` input, NUM_REQ bits: requester i has a write-back pending.
- `req_ready_o` output, NUM_REQ bits: requester i is granted this cycle. One-hot or zero.
- `req_addr_i` input, NUM_REQ*AW bits: destination register of each requester, packed with i at the LSB slice.
- `req_data_i` input, NUM_REQ*DATA_W bits: write data.
- `req_flag_we_i` input, NUM_REQ bits: requester also updates flags.
- `req_flag_i` input, NUM_REQ*FLAG_W bits: flag value.
- `rsv_valid_i` input, 1 bit: issue stage requests a reservation of `rsv_addr_i`.
- `rsv_addr_i` input, AW bits: register to reserve.
- `rsv_ready_o` output, 1 bit: reservation accepted this cycle.
- `busy_o` output, 2^AW bits: reservation bitmap, one bit per register.
- `wb_o` output, 1 bit: register-file write strobe.
- `wb_addr_o` output, AW bits: write address.
- `wb_data_o` output, DATA_W bits: write data.
- `flag_write_o` output, 1 bit: flag register write strobe.
- `flag_data_o` output, FLAG_W bits: flag data.

## Operation
- **Grant rule.** Round-robin over the requesters whose `req_valid_i` is high.
  - The search starts at pointer `ptr`.
  - The winner is the first valid index at or after `ptr`, wrapping modulo NUM_REQ.
- **Handshake.** A transfer happens when `req_valid_i[i] && req_ready_o[i]`.
  - On a transfer, `ptr` becomes winner+1, wrapping at NUM_REQ-1 → 0.
  - With no transfer, `ptr` holds.
  - `req_ready_o` is combinational from the `req_valid_i` inputs and `ptr`.
  - The output stage always accepts, so a valid requester is never stalled except by losing arbitration.
- **Requester rules.** A requester must hold valid, address, data and flag inputs stable until granted. Dropping valid before the grant is illegal.
- **Output stage.** Registered. The accepted request drives `wb_o`, `wb_addr_o` and `wb_data_o` for exactly one cycle. `flag_write_o` equals `req_flag_we_i` of the winner.
- **Idle outputs.** When `wb_o`/`flag_write_o` are low, data outputs hold their last values.
- **Scoreboard.** `busy_o` is a register, and 1 means a write is outstanding.
  - Reservation: `rsv_ready_o = rsv_valid_i && !busy[rsv_addr_i]`. An accepted reservation sets the bit.
  - Write-back clear: clears `busy[wb_addr_o]` on the edge that ends the `wb_o` cycle.
  - Same-edge conflict on the same address: the set wins and the bit stays 1.
  - Reserving an already-busy register is refused (WAW stall). The issue stage retries.
- **Width rules.** The address is truncated to AW bits, and there is no range error. Flags are independent of the register address.

## Timing
- Reset (`rst`=0, asynchronous) drives these values:
  - `ptr`=0.
  - `busy_o`=0.
  - `wb_o`=0 and `flag_write_o`=0.
  - `wb_addr_o`=0, `wb_data_o`=0, `flag_data_o`=0.
  - Only combinationally derived outputs follow their inputs during reset: `req_ready_o`=0 and `rsv_ready_o`=0 while `rst` is low.
- Reset mid-operation drops any in-flight write-back. Requesters retry after reset.
- Accept in cycle N leads to `wb_o`=1 in cycle N+1. The register cell writes at the end of N+1, and the busy bit reads 0 from cycle N+2.
- RAW-safe rule: when `busy_o[r]` reads 0, the register file value of r is current.
- Throughput: one write-back per cycle sustained. Each of K continuously valid requesters is served once every K cycles.
- A reservation accepted in cycle N shows as `busy_o`=1 from N+1.

## Configuration
- `WB_ARB_ERR_EN`: when defined, adds output `err_o` (1 bit, reset 0).
  - `err_o` is a sticky flag. It is set on the edge ending a `wb_o` cycle whose address was not busy (write-back without reservation).
  - Only reset clears it.
- When `WB_ARB_ERR_EN` is undefined, the port and its logic are absent, and such writes proceed silently.

## Structure
- Shared package `venus_wb_pkg`: `DATA_W`, `AW`, `FLAG_W` constants and the `wb_req_t` typedef (addr, data, flag_we, flag).
- One sub-module, `rr_arbiter` (parameter N): inputs `valid`, outputs one-hot `grant`, with its own `ptr` register updated on grant. Scoreboard and output stage stay in the top module.

## Test plan
- **Reset:** assert `rst`=0 mid-stream → all outputs read 0 immediately, and after release `ptr`=0, so requester 0 wins first.
- **Round-robin:** all three requesters valid continuously with addresses 1, 2, 3 → grants go 0,1,2,0,1,2, and `wb_addr_o` shows 1,2,3,1,2,3 one cycle later.
- **Reservation cycle:**
  - Reserve r5, then requester 1 writes r5 with data 0xDEADBEEF → `busy_o[5]`=1.
  - `wb_o`=1 with data 0xDEADBEEF in N+1.
  - `busy_o[5]`=0 in N+2.
- **WAW stall:** reserve r7 twice, back-to-back → second `rsv_ready_o`=0 until r7's write-back retires, then accepted.
- **Same-edge set/clear:** reserve r9 on the same edge that r9's write-back clears it → `busy_o[9]` stays 1.
- **Flags / error:**
  - Requester 2 writes flags 6'b101010 with `req_flag_we_i`=1 → `flag_write_o`=1 with `flag_data_o`=6'b101010 in N+1.
  - With `WB_ARB_ERR_EN`, a write to unreserved r3 → `err_o`=1 and stays set.
